// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage. IF/ID register, control decode,
// immediate generation, register file with write-through bypass,
// load-use stall detection and an ID/EX register with flush/bubble.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_f, instr_f, pc_f    fetch bundle
//   flush                     kill IF/ID and ID/EX contents
//   wb_en, wb_addr, wb_data   writeback port
//   stall_f                   fetch must hold PC/instr
//   *_e                       registered execute-stage bundle
//   a0                        live content of x10
module decode_pipe #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 5,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_f,
  input  logic [31:0]               instr_f,
  input  logic [DATA_WIDTH-1:0]     pc_f,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      stall_f,
  output logic                      valid_e,
  output logic [DATA_WIDTH-1:0]     pc_e,
  output logic [DATA_WIDTH-1:0]     rd1_e,
  output logic [DATA_WIDTH-1:0]     rd2_e,
  output logic [DATA_WIDTH-1:0]     imm_e,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      alu_src_e,
  output logic                      branch_e,
  output logic                      jump_e,
  output logic                      illegal_e,
  output logic [1:0]                result_src_e,
  output logic [3:0]                alu_control_e,
  output logic [2:0]                funct3_e,
  output logic [DATA_WIDTH-1:0]     a0
);

  localparam int DW   = DATA_WIDTH;
  localparam int AW   = REG_ADDR_WIDTH;
  localparam int NREG = 1 << AW;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          reg_write;
    logic          mem_write;
    logic          alu_src;
    logic          branch;
    logic          jump;
    logic          illegal;
    logic [1:0]    result_src;
    logic [3:0]    alu;
    logic [2:0]    funct3;
  } id_ex_t;

  logic [31:0]   ifid_instr_q, ifid_instr_d;
  logic [DW-1:0] ifid_pc_q, ifid_pc_d;
  logic          ifid_valid_q, ifid_valid_d;
  id_ex_t        idex_q, idex_d, dec;
  logic [DW-1:0] regs_q [NREG];

  logic [31:0]   ins;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [AW-1:0] rs1, rs2, rd;
  logic [DW-1:0] rd1, rd2;
  logic [3:0]    alu_f3;
  logic          is_r, is_i, is_ld, is_st, is_br;
  logic          is_jal, is_jalr, is_lui, is_auipc;
  logic          rs1_used, rs2_used, ld_use;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign ins = ifid_instr_q;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign rs1 = ins[15 +: AW];
  assign rs2 = ins[20 +: AW];
  assign rd  = ins[7 +: AW];

  assign is_r     = opc == OP_R;
  assign is_i     = opc == OP_I;
  assign is_ld    = opc == OP_LD;
  assign is_st    = opc == OP_ST;
  assign is_br    = opc == OP_BR;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  // instr[30] selects SUB only for R-type; SRA for both R and I
  always_comb begin
    alu_f3 = ALU_ADD;
    case (f3)
      3'b000: alu_f3 = (is_r && ins[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_f3 = ALU_SLL;
      3'b010: alu_f3 = ALU_SLT;
      3'b011: alu_f3 = ALU_SLTU;
      3'b100: alu_f3 = ALU_XOR;
      3'b101: alu_f3 = ins[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  // register reads with write-through bypass; x0 is hardwired
  always_comb begin
    rd1 = regs_q[rs1];
    rd2 = regs_q[rs2];
    if (rs1 == '0) rd1 = '0;
    else if (wb_en && wb_addr == rs1) rd1 = wb_data;
    if (rs2 == '0) rd2 = '0;
    else if (wb_en && wb_addr == rs2) rd2 = wb_data;
  end

  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.valid  = ifid_valid_q;
    dec.pc     = ifid_pc_q;
    dec.rd1    = rd1;
    dec.rd2    = rd2;
    dec.rs1    = rs1;
    dec.rs2    = rs2;
    dec.rd     = rd;
    dec.funct3 = f3;
    unique case (1'b1)
      is_r: begin
        dec.reg_write = 1'b1;
        dec.alu       = alu_f3;
      end
      is_i: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu       = alu_f3;
        imm32         = imm_i;
      end
      is_ld: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        imm32          = imm_i;
      end
      is_st: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_s;
      end
      is_br: begin
        dec.branch = 1'b1;
        dec.alu    = ALU_SUB;
        imm32      = imm_b;
      end
      is_jal: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        imm32          = imm_j;
      end
      is_jalr: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        imm32          = imm_i;
      end
      is_lui: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu       = ALU_PASS;
        imm32         = imm_u;
      end
      is_auipc: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm32         = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = DW'(imm32);
  end

  assign rs1_used = !(is_lui || is_auipc || is_jal);
  assign rs2_used = is_r || is_st || is_br;

  assign ld_use = idex_q.valid && idex_q.reg_write &&
                  idex_q.result_src == 2'b01 &&
                  idex_q.rd != '0 &&
                  ((rs1_used && idex_q.rd == rs1) ||
                   (rs2_used && idex_q.rd == rs2));

  assign stall_f = ld_use && !rst;

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall_f) begin
      ifid_instr_d = instr_f;
      ifid_pc_d    = pc_f;
      ifid_valid_d = valid_f;
    end
  end

  // an empty IF/ID slot also enters ID/EX as a bubble
  always_comb begin
    idex_d = dec;
    if (flush || stall_f || !ifid_valid_q) idex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign valid_e       = idex_q.valid;
  assign pc_e          = idex_q.pc;
  assign rd1_e         = idex_q.rd1;
  assign rd2_e         = idex_q.rd2;
  assign imm_e         = idex_q.imm;
  assign rs1_e         = idex_q.rs1;
  assign rs2_e         = idex_q.rs2;
  assign rd_e          = idex_q.rd;
  assign reg_write_e   = idex_q.reg_write;
  assign mem_write_e   = idex_q.mem_write;
  assign alu_src_e     = idex_q.alu_src;
  assign branch_e      = idex_q.branch;
  assign jump_e        = idex_q.jump;
  assign illegal_e     = idex_q.illegal;
  assign result_src_e  = idex_q.result_src;
  assign alu_control_e = idex_q.alu;
  assign funct3_e      = idex_q.funct3;
  assign a0            = regs_q[AW'(10)];

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Pipelined decode stage for the RV32I core, successor to the single-cycle decode top.
- Holds the IF/ID register, the control decoder, immediate generation and a register file with write-through bypass.
- Detects load-use hazards and produces the stall.
- Registers everything into an ID/EX register, with flush and bubble insertion, feeding the execute stage.

Parameters:
- DATA_WIDTH, 32, datapath/register width.
- REG_ADDR_WIDTH, 5, register index width (4 gives RV32E, 16 regs).
- NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on flush/reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_f  in  1  fetch presents a valid instruction
- instr_f  in  32  fetched instruction
- pc_f  in  DATA_WIDTH  PC of instr_f
- flush  in  1  taken branch/jump resolved in execute; kill IF/ID and ID/EX contents
- wb_en  in  1  writeback enable
- wb_addr  in  REG_ADDR_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback value
- stall_f  out  1  combinational; fetch must hold PC and instr_f
- valid_e  out  1  ID/EX slot holds a real instruction
- pc_e, rd1_e, rd2_e, imm_e  out  DATA_WIDTH  registered PC, operands, extended immediate
- rs1_e, rs2_e, rd_e  out  REG_ADDR_WIDTH  registered register indices (for forwarding)
- reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, illegal_e  out  1  registered controls
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
- alu_control_e  out  4  ALU operation code
- funct3_e  out  3  branch/load/store sub-op
- a0  out  DATA_WIDTH  live content of x10, for display

Behaviour:
- Reset (rst=1 at edge):
  - IF/ID: instr=NOP_INSTR, valid=0, pc=0.
  - All ID/EX outputs 0.
  - All registers cleared to 0, so a0=0.
  - Reset mid-operation discards in-flight instructions; stall_f=0 while rst=1.
- IF/ID register:
  - Loads instr_f/pc_f/valid_f each edge unless stall_f=1, in which case it holds.
  - Loads NOP_INSTR with valid=0 if flush=1.
- Latency: instruction captured into IF/ID at edge k appears on *_e after edge k+1 (no stall).
- Register file:
  - 2^REG_ADDR_WIDTH entries; writes on edge when wb_en=1 and wb_addr!=0.
  - x0 always reads 0.
  - Read bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs1 (rs2), rd1 (rd2) returns wb_data in the same cycle.
- Decode (combinational on IF/ID instr):
  - Opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B.
  - SUB/SRA selected by instr[30]; instr[30] is ignored for ADDI.
  - LOAD/STORE/JALR/AUIPC use ADD.
  - BRANCH uses SUB and sets branch_e.
  - LUI uses PASS_B.
  - JAL/JALR set jump_e and result_src=10.
- Immediates, sign-extended to DATA_WIDTH:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- Illegal opcode: illegal_e=1, reg_write/mem_write/branch/jump=0, valid_e still follows valid.
- Load-use hazard:
  - Condition: valid_e=1, result_src_e=01, reg_write_e=1, rd_e!=0, and either:
    - rd_e==rs1 where rs1 is used (all except LUI/AUIPC/JAL), or
    - rd_e==rs2 where rs2 is used (R/STORE/BRANCH).
  - Response: stall_f=1, IF/ID holds, ID/EX loads a bubble (valid_e=0, all controls 0).
  - Releases after exactly one bubble.
- Flush:
  - ID/EX loads a bubble and IF/ID loads NOP at that edge.
  - flush overrides stall; stall_f still reflects the hazard but has no effect on IF/ID.
- Simultaneous writeback and decode of the same register: bypassed value is captured.
- Writeback to rd_e in the same cycle as a stall: register file write still occurs.

Test Plan:
- Reset, then ADDI x10,x0,5 (0x00500513) valid at edge 1 -> after edge 2: valid_e=1, alu_control_e=0000, alu_src_e=1, imm_e=5, rd_e=10, reg_write_e=1; with wb_en=1, wb_addr=10, wb_data=5 next edge, a0=5.
- Bypass: ADD x3,x1,x2 in ID while wb_en=1, wb_addr=1, wb_data=0xDEADBEEF -> rd1_e=0xDEADBEEF after edge; wb_addr=0, wb_data=7 -> x0 stays 0.
- Load-use: LW x5,0(x1) followed by ADD x6,x5,x7 -> stall_f=1 for one cycle, one bubble (valid_e=0), then ADD reaches *_e with rs1_e=5; with x5 unrelated, stall_f never asserts.
- Flush: flush=1 while SW is in IF/ID and BEQ in ID/EX -> next edge valid_e=0, mem_write_e=0; IF/ID holds NOP; flush and load-use together -> bubble, no hold.
- Immediates: BEQ with offset -4 (0xFE000EE3) -> imm_e=0xFFFFFFFC, branch_e=1, alu_control_e=0001; LUI x1,0x12345 -> imm_e=0x12345000, alu_control_e=1010.
- rst pulse mid-stream with stall active -> next cycle all outputs 0, stall_f=0, a0=0; opcode 0x7F -> illegal_e=1, reg_write_e=0.
